song_sequencer: RTL and testbench

//  Auto-play stage directly upstream of the buzzer tone generator. Walks a song table held in an

---
 rtl/song_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_song_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// song_sequencer: auto-play stage in front of the buzzer tone generator.
// It walks a song table in an external synchronous ROM one entry at a time. Each
// entry sounds its note for len*UNIT_TICKS-GAP_TICKS ticks and is then silent for
// GAP_TICKS ticks. The sequencer handles start, stop, level pause and end of song.
//
// Ports
//   clk       in   1        system clock
//   rst       in   1        synchronous, active-high reset
//   start     in   1        begin playing song_sel (accepted only in IDLE)
//   stop      in   1        abort playback and return to IDLE
//   pause     in   1        level; freezes playback while high
//   song_sel  in   2        song number, latched when start is accepted
//   rom_addr  out  IDX_W+2  {song, idx} ROM read address
//   rom_data  in   11       ROM word, valid 1 cycle after rom_addr:
//                           [10]=END [9:8]=mode [7:4]=note [3:0]=len (0 means 16)
//   note      out  4        buzzer note; 0 = silence
//   mode      out  2        buzzer octave mode
//   playing   out  1        high from FETCH through the last GAP, PAUSED included
//   done      out  1        one-cycle pulse on natural end of song
//   pos       out  IDX_W    index of the entry currently sounding
module song_sequencer #(
    parameter int TICK_DIV   = 100_000,
    parameter int UNIT_TICKS = 125,
    parameter int GAP_TICKS  = 20,
    parameter int IDX_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [1:0]       song_sel,
    output logic [IDX_W+1:0] rom_addr,
    input  logic [10:0]      rom_data,
    output logic [3:0]       note,
    output logic [1:0]       mode,
    output logic             playing,
    output logic             done,
    output logic [IDX_W-1:0] pos
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ENT_W  = $clog2(16 * UNIT_TICKS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SOUND,
        ST_GAP,
        ST_PAUSED,
        ST_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    state_t            r_saved;
    logic [1:0]        r_song_q;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_pos;
    logic [3:0]        r_note;
    logic [1:0]        r_mode;
    logic [TICK_W-1:0] r_tick;
    logic [ENT_W-1:0]  r_ent;
    logic [ENT_W-1:0]  r_snd_last;
    logic [ENT_W-1:0]  r_ent_last;

    logic              w_end_flag;
    logic [4:0]        w_len_units;
    logic [ENT_W-1:0]  w_total;
    logic              w_tick;
    logic              w_snd_end;
    logic              w_gap_end;

    assign w_end_flag  = rom_data[10];
    assign w_len_units = (rom_data[3:0] == 4'd0) ? 5'd16 : {1'b0, rom_data[3:0]};
    assign w_total     = ENT_W'(w_len_units) * ENT_W'(UNIT_TICKS);
    assign w_tick      = (r_tick == TICK_W'(TICK_DIV - 1));

    // The entry counter runs across the whole entry: sound ends at r_snd_last and
    // the gap ends at r_ent_last, so the gap needs no counter of its own.
    assign w_snd_end   = (r_state == ST_SOUND) && w_tick && (r_ent == r_snd_last);
    assign w_gap_end   = (r_state == ST_GAP) && w_tick && (r_ent == r_ent_last);

    assign rom_addr = {r_song_q, r_idx};
    assign mode     = r_mode;
    assign pos      = r_pos;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        note    = '0;
        playing = 1'b0;
        done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                playing = 1'b1;
                w_next  = ST_LOAD;
            end
            ST_LOAD: begin
                playing = 1'b1;
                if (w_end_flag)  w_next = ST_DONE;
                else if (pause)  w_next = ST_PAUSED;
                else             w_next = ST_SOUND;
            end
            ST_SOUND: begin
                playing = 1'b1;
                note    = r_note;
                if (pause)           w_next = ST_PAUSED;
                else if (w_snd_end)  w_next = ST_GAP;
            end
            ST_GAP: begin
                playing = 1'b1;
                // Finishing the entry takes priority; a held pause is seen at the next SOUND.
                if (w_gap_end)   w_next = (r_idx == '1) ? ST_DONE : ST_FETCH;
                else if (pause)  w_next = ST_PAUSED;
            end
            ST_PAUSED: begin
                playing = 1'b1;
                if (!pause) w_next = r_saved;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        // stop overrides everything, including a start presented in IDLE
        if (stop) w_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_saved    <= ST_SOUND;
            r_song_q   <= '0;
            r_idx      <= '0;
            r_pos      <= '0;
            r_note     <= '0;
            r_mode     <= '0;
            r_tick     <= '0;
            r_ent      <= '0;
            r_snd_last <= '0;
            r_ent_last <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_next == ST_FETCH) begin
                        r_song_q <= song_sel;
                        r_idx    <= '0;
                        r_tick   <= '0;
                        r_ent    <= '0;
                    end
                end
                ST_LOAD: begin
                    r_tick <= '0;
                    r_ent  <= '0;
                    if (!w_end_flag) begin
                        r_mode     <= rom_data[9:8];
                        r_note     <= rom_data[7:4];
                        r_pos      <= r_idx;
                        r_snd_last <= w_total - ENT_W'(GAP_TICKS + 1);
                        r_ent_last <= w_total - ENT_W'(1);
                    end
                end
                ST_SOUND, ST_GAP: begin
                    if (w_tick) begin
                        r_tick <= '0;
                        r_ent  <= r_ent + ENT_W'(1);
                    end else begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                    if (w_next == ST_FETCH) r_idx <= r_idx + IDX_W'(1);
                end
                default: ;
            endcase
            // The cycle that samples pause still counts, so if it was the last sound
            // tick the resume point is already the gap.
            if (w_next == ST_PAUSED && r_state != ST_PAUSED) begin
                r_saved <= (r_state == ST_GAP || w_snd_end) ? ST_GAP : ST_SOUND;
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed bench for song_sequencer with small timing parameters
// (TICK_DIV=4, UNIT_TICKS=3, GAP_TICKS=1, IDX_W=3) and a 1-cycle synchronous ROM.
// Expected sounding segments and done pulses are queued when a song is started. A
// monitor pops them as the DUT output produces each segment or done pulse.
module tb_song_sequencer;

    localparam int TD      = 4;
    localparam int UT      = 3;
    localparam int GT      = 1;
    localparam int IW      = 3;
    localparam int GAP_CYC = GT * TD;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          pause;
    logic [1:0]    song_sel;
    logic [IW+1:0] rom_addr;
    logic [10:0]   rom_data;
    logic [3:0]    note;
    logic [1:0]    mode;
    logic          playing;
    logic          done;
    logic [IW-1:0] pos;

    logic [10:0] rom [32];
    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    typedef struct {
        bit is_done;
        int note;
        int mode;
        int pos;
        int cyc;
        int len;
    } exp_t;
    exp_t sb[$];

    bit m_in_run = 1'b0;
    int m_n, m_m, m_p, m_c, m_l;

    song_sequencer #(
        .TICK_DIV   (TD),
        .UNIT_TICKS (UT),
        .GAP_TICKS  (GT),
        .IDX_W      (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .song_sel (song_sel),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .note     (note),
        .mode     (mode),
        .playing  (playing),
        .done     (done),
        .pos      (pos)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom[rom_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int snd_cyc(input logic [3:0] len);
        int units;
        units = (len == 4'd0) ? 16 : int'(len);
        return (units * UT - GT) * TD;
    endfunction

    // Queue the expected segments and done pulse for a song started in cycle t.
    task automatic push_song(input int s, input int t);
        logic [10:0] w;
        int f;
        bit ended;
        f = t + 1;
        ended = 1'b0;
        for (int k = 0; k < 8 && !ended; k++) begin
            w = rom[s * 8 + k];
            if (w[10]) begin
                sb.push_back('{1'b1, 0, 0, 0, f + 2, 0});
                ended = 1'b1;
            end else begin
                if (w[7:4] != 4'd0)
                    sb.push_back('{1'b0, int'(w[7:4]), int'(w[9:8]), k, f + 2, snd_cyc(w[3:0])});
                f = f + 2 + snd_cyc(w[3:0]) + GAP_CYC;
            end
        end
        if (!ended) sb.push_back('{1'b1, 0, 0, 0, f, 0});
    endtask

    task automatic fin_seg(input int n, input int m, input int p, input int c, input int l);
        exp_t e;
        chk("seg_avail", {31'b0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("seg_kind", {31'b0, e.is_done}, 0);
            chk("seg_note", n, e.note);
            chk("seg_mode", m, e.mode);
            chk("seg_pos", p, e.pos);
            chk("seg_start", c, e.cyc);
            chk("seg_len", l, e.len);
        end
    endtask

    task automatic fin_done(input int c);
        exp_t e;
        chk("done_avail", {31'b0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("done_kind", {31'b0, e.is_done}, 1);
            chk("done_cyc", c, e.cyc);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (m_in_run && note !== 4'(m_n)) begin
                    fin_seg(m_n, m_m, m_p, m_c, m_l);
                    m_in_run = 1'b0;
                end
                if (note !== 4'd0) begin
                    if (!m_in_run) begin
                        m_in_run = 1'b1;
                        m_n = int'(note);
                        m_m = int'(mode);
                        m_p = int'(pos);
                        m_c = cyc;
                        m_l = 1;
                    end else begin
                        m_l++;
                    end
                end
                if (done === 1'b1) fin_done(cyc);
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic kick(input logic [1:0] s);
        song_sel = s;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
        $fatal(1);
    end

    initial begin : main
        int t;
        int s2_note [8] = '{1, 2, 0, 4, 5, 6, 7, 3};
        int s2_mode [8] = '{0, 1, 2, 0, 1, 2, 0, 1};
        int s2_len  [8] = '{1, 1, 1, 3, 1, 1, 1, 2};

        foreach (rom[i]) rom[i] = 11'h400;
        rom[0]  = {1'b0, 2'b01, 4'd5, 4'd2};
        rom[8]  = {1'b0, 2'b10, 4'd3, 4'd0};
        for (int k = 0; k < 8; k++)
            rom[16 + k] = {1'b0, 2'(s2_mode[k]), 4'(s2_note[k]), 4'(s2_len[k])};
        rom[24] = {1'b0, 2'b00, 4'd7, 4'd2};

        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; song_sel = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_note", note, 0);
        chk("rst_mode", mode, 0);
        chk("rst_playing", playing, 0);
        chk("rst_done", done, 0);
        chk("rst_pos", pos, 0);
        chk("rst_addr", rom_addr, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // single entry then END
        t = cyc;
        push_song(0, t);
        kick(2'd0);
        goto(t + 2);
        chk("t1_load_note", note, 0);
        chk("t1_load_playing", playing, 1);
        goto(t + 3);
        chk("t1_note", note, 5);
        chk("t1_mode", mode, 1);
        goto(t + 23);
        chk("t1_gap_note", note, 0);
        chk("t1_gap_mode", mode, 1);
        chk("t1_gap_playing", playing, 1);
        goto(t + 29);
        chk("t1_done", done, 1);
        chk("t1_done_playing", playing, 0);
        goto(t + 30);
        chk("t1_done_after", done, 0);
        chk("t1_note_after", note, 0);
        drain(20);

        // len=0 decodes as 16 units
        t = cyc;
        push_song(1, t);
        kick(2'd1);
        goto(t + 100);
        chk("t2_note", note, 3);
        chk("t2_mode", mode, 2);
        drain(300);

        // pause mid-sound for 10 cycles
        t = cyc;
        sb.push_back('{1'b0, 7, 0, 0, t + 3, 6});
        sb.push_back('{1'b0, 7, 0, 0, t + 19, 14});
        sb.push_back('{1'b1, 0, 0, 0, t + 39, 0});
        kick(2'd3);
        goto(t + 8);
        pause = 1'b1;
        goto(t + 12);
        chk("t3_paused_note", note, 0);
        chk("t3_paused_playing", playing, 1);
        goto(t + 18);
        pause = 1'b0;
        drain(60);

        // stop and start together mid-gap, then replay
        t = cyc;
        sb.push_back('{1'b0, 5, 1, 0, t + 3, 20});
        kick(2'd0);
        goto(t + 24);
        stop  = 1'b1;
        start = 1'b1;
        goto(t + 25);
        stop  = 1'b0;
        start = 1'b0;
        chk("t4_stop_playing", playing, 0);
        chk("t4_stop_note", note, 0);
        chk("t4_stop_done", done, 0);
        goto(t + 40);
        chk("t4_idle_playing", playing, 0);
        drain(5);
        t = cyc;
        push_song(0, t);
        kick(2'd0);
        drain(60);

        // eight entries without END, plus mid-song start and song_sel change
        t = cyc;
        push_song(2, t);
        kick(2'd2);
        for (int i = 0; i < 400 && sb.size() != 0; i++) begin
            if (i == 40) begin
                start    = 1'b1;
                song_sel = 2'd1;
            end
            if (i == 41) start = 1'b0;
            @(negedge clk);
            if (playing === 1'b1) chk("t5_addr_song", rom_addr[IW+1:IW], 2);
        end
        drain(10);

        // reset during sound of entry 1
        t = cyc;
        sb.push_back('{1'b0, 1, 0, 0, t + 3, 8});
        sb.push_back('{1'b0, 2, 1, 1, t + 17, 4});
        kick(2'd2);
        goto(t + 20);
        chk("t6_pre_pos", pos, 1);
        rst   = 1'b1;
        start = 1'b1;
        goto(t + 21);
        chk("t6_rst_note", note, 0);
        chk("t6_rst_mode", mode, 0);
        chk("t6_rst_playing", playing, 0);
        chk("t6_rst_pos", pos, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_addr", rom_addr, 0);
        goto(t + 23);
        chk("t6_hold_playing", playing, 0);
        rst   = 1'b0;
        start = 1'b0;
        goto(t + 28);
        chk("t6_after_playing", playing, 0);
        drain(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
